load_store_ctrl: RTL and testbench

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

---
 rtl/load_store_ctrl_pkg.sv | 47 ++++
 rtl/load_store_ctrl_lane_extract.sv | 36 +++
 rtl/load_store_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_load_store_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_ctrl_pkg.sv
// Shared encodings for the load/store controller: operation codes, FSM
// states, byte-enable patterns and the alignment rule.
package load_store_ctrl_pkg;

  // Load operation encodings; any other value is a full-word load.
  localparam logic [2:0] LOADOP_LB  = 3'b001;
  localparam logic [2:0] LOADOP_LBU = 3'b010;
  localparam logic [2:0] LOADOP_LH  = 3'b011;
  localparam logic [2:0] LOADOP_LHU = 3'b100;

  // Store operation encodings; any other value is a full-word store.
  localparam logic [1:0] STOREOP_SB = 2'b01;
  localparam logic [1:0] STOREOP_SH = 2'b10;

  // Byte-enable patterns.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Halfword accesses need an even address, word accesses a word-aligned
  // one; byte accesses are always aligned.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [2:0] lop,
                                         input logic [1:0] sop,
                                         input logic [1:0] byte_off);
    logic mis;
    if (is_load) begin
      if (lop == LOADOP_LB || lop == LOADOP_LBU)      mis = 1'b0;
      else if (lop == LOADOP_LH || lop == LOADOP_LHU) mis = byte_off[0];
      else                                            mis = (byte_off != 2'b00);
    end else begin
      if (sop == STOREOP_SB)      mis = 1'b0;
      else if (sop == STOREOP_SH) mis = byte_off[0];
      else                        mis = (byte_off != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_store_ctrl_lane_extract.sv
// Selects the addressed byte/halfword lane from a raw read word and
// sign- or zero-extends it according to the load operation.
module load_lane_extract
  import load_store_ctrl_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  loadop,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select followed by extension; full-word loads pass through.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    lane_b = raw_word[7:0];
    lane_h = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
    data   = raw_word;
    case (byte_off)
      2'd1:    lane_b = raw_word[15:8];
      2'd2:    lane_b = raw_word[23:16];
      2'd3:    lane_b = raw_word[31:24];
      default: lane_b = raw_word[7:0];
    endcase
    case (loadop)
      LOADOP_LB:  data = {{24{lane_b[7]}}, lane_b};
      LOADOP_LBU: data = {24'h000000, lane_b};
      LOADOP_LH:  data = {{16{lane_h[15]}}, lane_h};
      LOADOP_LHU: data = {16'h0000, lane_h};
      default:    data = raw_word;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Memory-stage load/store controller: accepts one pipeline request, checks
// alignment, drives a held memory request with lane-replicated store data,
// aligns load data and reports completion with address or timeout faults.
module load_store_ctrl
  import load_store_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  loadop,
  input  logic [1:0]  storeop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               is_load_q, is_load_d;
  logic [2:0]         loadop_q, loadop_d;
  logic [1:0]         byte_off_q, byte_off_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               done_q, done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               addr_err_q, addr_err_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        ext_data;

  load_lane_extract u_lane_extract (
    .raw_word (mem_rdata),
    .byte_off (byte_off_q),
    .loadop   (loadop_q),
    .data     (ext_data)
  );

  // Next-state and registered-output logic for the IDLE/ACCESS/DONE FSM.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    is_load_d   = is_load_q;
    loadop_d    = loadop_q;
    byte_off_d  = byte_off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_load_d  = req_load;
          loadop_d   = loadop;
          byte_off_d = req_addr[1:0];
          mem_addr_d = {req_addr[31:2], 2'b00};
          wait_cnt_d = '0;
          rdata_d    = 32'h0;
          addr_err_d = 1'b0;
          bus_err_d  = 1'b0;
          if (is_misaligned(req_load, loadop, storeop, req_addr[1:0])) begin
            // Faulting requests skip the memory entirely.
            state_d    = DONE;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            mem_req_d = 1'b1;
            mem_we_d  = ~req_load;
            if (req_load) begin
              mem_be_d    = BE_ALL;
              mem_wdata_d = 32'h0;
            end else if (storeop == STOREOP_SB) begin
              mem_be_d    = BE_BYTE0 << req_addr[1:0];
              mem_wdata_d = {4{req_wdata[7:0]}};
            end else if (storeop == STOREOP_SH) begin
              mem_be_d    = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
              mem_wdata_d = {2{req_wdata[15:0]}};
            end else begin
              mem_be_d    = BE_ALL;
              mem_wdata_d = req_wdata;
            end
          end
        end
      end

      ACCESS: begin
        // mem_ready is checked first so it wins over a coincident timeout.
        if (mem_ready) begin
          state_d   = DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = BE_NONE;
          if (is_load_q) rdata_d = ext_data;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = BE_NONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Any req_valid seen here is left for the following IDLE cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      is_load_q   <= 1'b0;
      loadop_q    <= 3'b000;
      byte_off_q  <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= BE_NONE;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_load_q   <= is_load_d;
      loadop_q    <= loadop_d;
      byte_off_q  <= byte_off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Stall must react to req_valid in the same cycle, so it is decoded from state.
  always_comb begin
    stall = (state_q == ACCESS) || ((state_q == IDLE) && req_valid);
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: one task per scenario with inline
// comparisons against hand-computed values.
module tb_load_store_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_load;
  logic [2:0]  loadop;
  logic [1:0]  storeop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_load  (req_load),
    .loadop    (loadop),
    .storeop   (storeop),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_load = 1'b0; loadop = 3'b000; storeop = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req: got %h expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we: got %h expected 0", mem_we); end
    checks++; if (mem_be !== 4'h0)    begin errors++; $display("FAIL rst_mem_be: got %h expected 0", mem_be); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %h expected 0", done); end
    checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL rst_stall: got %h expected 0", stall); end
    checks++; if (rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    checks++; if (addr_err !== 1'b0)  begin errors++; $display("FAIL rst_addr_err: got %h expected 0", addr_err); end
    checks++; if (bus_err !== 1'b0)   begin errors++; $display("FAIL rst_bus_err: got %h expected 0", bus_err); end
    rst = 1'b0;
    tick();
  endtask

  // LB at 0x1003, ready two cycles after mem_req rises.
  task automatic test_load_byte();
    req_valid = 1'b1; req_load = 1'b1; loadop = 3'b001; req_addr = 32'h0000_1003;
    #1;
    checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL lb_stall_n0: got %h expected 1", stall); end
    tick();  // N+1
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL lb_mem_req_n1: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h1000)   begin errors++; $display("FAIL lb_mem_addr: got %h expected 00001000", mem_addr); end
    checks++; if (mem_be !== 4'hF)         begin errors++; $display("FAIL lb_mem_be: got %h expected f", mem_be); end
    checks++; if (mem_we !== 1'b0)         begin errors++; $display("FAIL lb_mem_we: got %h expected 0", mem_we); end
    checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL lb_stall_n1: got %h expected 1", stall); end
    tick();  // N+2
    checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL lb_mem_req_n2: got %h expected 1", mem_req); end
    checks++; if (done !== 1'b0)           begin errors++; $display("FAIL lb_done_n2: got %h expected 0", done); end
    checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL lb_stall_n2: got %h expected 1", stall); end
    tick();  // N+3
    mem_ready = 1'b1; mem_rdata = 32'h80FF_7F01;
    checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL lb_stall_n3: got %h expected 1", stall); end
    tick();  // N+4
    mem_ready = 1'b0;
    checks++; if (done !== 1'b1)           begin errors++; $display("FAIL lb_done_n4: got %h expected 1", done); end
    checks++; if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", rdata); end
    checks++; if (stall !== 1'b0)          begin errors++; $display("FAIL lb_stall_n4: got %h expected 0", stall); end
    checks++; if (mem_req !== 1'b0)        begin errors++; $display("FAIL lb_mem_req_n4: got %h expected 0", mem_req); end
    checks++; if ({addr_err, bus_err} !== 2'b00) begin errors++; $display("FAIL lb_errs: got %b expected 00", {addr_err, bus_err}); end
    tick();  // N+5
    checks++; if (done !== 1'b0)           begin errors++; $display("FAIL lb_done_n5: got %h expected 0", done); end
  endtask

  // SH at 0x2002: upper half lanes, halfword replicated, held while waiting.
  task automatic test_store_half();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b0; storeop = 2'b10; req_addr = 32'h0000_2002; req_wdata = 32'h0000_BEEF;
    tick();
    req_valid = 1'b0; req_wdata = 32'h1234_5678; req_addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req !== 1'b1)          begin errors++; $display("FAIL sh_mem_req[%0d]: got %h expected 1", i, mem_req); end
      checks++; if (mem_be !== 4'b1100)        begin errors++; $display("FAIL sh_mem_be[%0d]: got %b expected 1100", i, mem_be); end
      checks++; if (mem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_mem_wdata[%0d]: got %h expected beefbeef", i, mem_wdata); end
      checks++; if (mem_we !== 1'b1)           begin errors++; $display("FAIL sh_mem_we[%0d]: got %h expected 1", i, mem_we); end
      checks++; if (mem_addr !== 32'h2000)     begin errors++; $display("FAIL sh_mem_addr[%0d]: got %h expected 00002000", i, mem_addr); end
      if (i == 1) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    checks++; if (done !== 1'b1)     begin errors++; $display("FAIL sh_done: got %h expected 1", done); end
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL sh_mem_req_done: got %h expected 0", mem_req); end
    checks++; if (rdata !== 32'h0)   begin errors++; $display("FAIL sh_rdata: got %h expected 0", rdata); end
    checks++; if ({addr_err, bus_err} !== 2'b00) begin errors++; $display("FAIL sh_errs: got %b expected 00", {addr_err, bus_err}); end
    tick();
  endtask

  // LW at 0x3001 and SH at 0x2001 fault without any memory access.
  task automatic test_misaligned();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b1; loadop = 3'b000; req_addr = 32'h0000_3001;
    tick();  // N+1
    req_valid = 1'b0;
    checks++; if (done !== 1'b1)     begin errors++; $display("FAIL lw_mis_done: got %h expected 1", done); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL lw_mis_addr_err: got %h expected 1", addr_err); end
    checks++; if (rdata !== 32'h0)   begin errors++; $display("FAIL lw_mis_rdata: got %h expected 0", rdata); end
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL lw_mis_mem_req: got %h expected 0", mem_req); end
    checks++; if (bus_err !== 1'b0)  begin errors++; $display("FAIL lw_mis_bus_err: got %h expected 0", bus_err); end
    tick();  // N+2
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL lw_mis_done_n2: got %h expected 0", done); end
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL lw_mis_mem_req_n2: got %h expected 0", mem_req); end
    req_valid = 1'b1; req_load = 1'b0; storeop = 2'b10; req_addr = 32'h0000_2001;
    tick();
    req_valid = 1'b0;
    checks++; if ({done, addr_err, mem_req} !== 3'b110) begin errors++; $display("FAIL sh_mis: got done/addr_err/mem_req %b expected 110", {done, addr_err, mem_req}); end
    tick();
  endtask

  // LHU at 0x4002 with no mem_ready: four request cycles, then bus error.
  task automatic test_timeout();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b1; loadop = 3'b100; req_addr = 32'h0000_4002;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++; if ({mem_req, done} !== 2'b10) begin errors++; $display("FAIL to_wait[%0d]: got mem_req/done %b expected 10", i, {mem_req, done}); end
      tick();
    end
    checks++; if (done !== 1'b1)     begin errors++; $display("FAIL to_done: got %h expected 1", done); end
    checks++; if (bus_err !== 1'b1)  begin errors++; $display("FAIL to_bus_err: got %h expected 1", bus_err); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL to_addr_err: got %h expected 0", addr_err); end
    checks++; if (rdata !== 32'h0)   begin errors++; $display("FAIL to_rdata: got %h expected 0", rdata); end
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL to_mem_req: got %h expected 0", mem_req); end
    tick();
  endtask

  // mem_ready on the last allowed cycle beats the timeout.
  task automatic test_timeout_race();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b1; loadop = 3'b100; req_addr = 32'h0000_4002;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL race_mem_req[%0d]: got %h expected 1", i, mem_req); end
      if (i == TIMEOUT - 1) begin
        mem_ready = 1'b1; mem_rdata = 32'h8765_4321;
      end
      tick();
    end
    mem_ready = 1'b0;
    checks++; if (done !== 1'b1)          begin errors++; $display("FAIL race_done: got %h expected 1", done); end
    checks++; if (bus_err !== 1'b0)       begin errors++; $display("FAIL race_bus_err: got %h expected 0", bus_err); end
    checks++; if (rdata !== 32'h0000_8765) begin errors++; $display("FAIL race_rdata: got %h expected 00008765", rdata); end
    tick();
  endtask

  // Reset in ACCESS drops the request with no completion pulse.
  task automatic test_reset_in_access();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b1; loadop = 3'b000; req_addr = 32'h0000_5000;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ra_mem_req_pre: got %h expected 1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ra_mem_req: got %h expected 0", mem_req); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL ra_done: got %h expected 0", done); end
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL ra_stall: got %h expected 0", stall); end
    checks++; if (mem_be !== 4'h0)  begin errors++; $display("FAIL ra_mem_be: got %h expected 0", mem_be); end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    checks++; if ({done, mem_req} !== 2'b00) begin errors++; $display("FAIL ra_idle: got done/mem_req %b expected 00", {done, mem_req}); end
    tick();
    checks++; if ({done, mem_req} !== 2'b00) begin errors++; $display("FAIL ra_idle2: got done/mem_req %b expected 00", {done, mem_req}); end
  endtask

  // SB at 0x6001 with req_valid held high: DONE ignores it, IDLE takes LBU.
  task automatic test_back_to_back();
    drive_idle();
    req_valid = 1'b1; req_load = 1'b0; storeop = 2'b01; req_addr = 32'h0000_6001; req_wdata = 32'h0000_00A5;
    tick();  // N+1 ACCESS
    req_load = 1'b1; loadop = 3'b010; req_addr = 32'h0000_7002; req_wdata = 32'h0;
    checks++; if (mem_be !== 4'b0010)         begin errors++; $display("FAIL sb_mem_be: got %b expected 0010", mem_be); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_mem_wdata: got %h expected a5a5a5a5", mem_wdata); end
    checks++; if (mem_addr !== 32'h6000)      begin errors++; $display("FAIL sb_mem_addr: got %h expected 00006000", mem_addr); end
    mem_ready = 1'b1;
    tick();  // N+2 DONE
    mem_ready = 1'b0;
    checks++; if (done !== 1'b1)    begin errors++; $display("FAIL b2b_done: got %h expected 1", done); end
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL b2b_stall_done: got %h expected 0", stall); end
    tick();  // N+3 IDLE, second request presented
    checks++; if (stall !== 1'b1)   begin errors++; $display("FAIL b2b_stall_idle: got %h expected 1", stall); end
    checks++; if ({done, mem_req} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got done/mem_req %b expected 00", {done, mem_req}); end
    tick();  // N+4 ACCESS for LBU
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1)      begin errors++; $display("FAIL lbu_mem_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h7000) begin errors++; $display("FAIL lbu_mem_addr: got %h expected 00007000", mem_addr); end
    checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL lbu_mem_we: got %h expected 0", mem_we); end
    mem_ready = 1'b1; mem_rdata = 32'h12C4_3456;
    tick();
    mem_ready = 1'b0;
    checks++; if (done !== 1'b1)          begin errors++; $display("FAIL lbu_done: got %h expected 1", done); end
    checks++; if (rdata !== 32'h0000_00C4) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000c4", rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_timeout_race();
    test_reset_in_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
